// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative multiply/divide sequencer owning the HI/LO pair
// Shift-add multiply and restoring divide, one bit per cycle, sign fixed up in FIX.
`timescale 1ns/1ps
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fixed;

  assign signed_op = (op == 3'd0) || (op == 3'd2);
  assign sgn_a     = signed_op & operandA[WIDTH-1];
  assign sgn_b     = signed_op & operandB[WIDTH-1];
  assign abs_a     = sgn_a ? (~operandA + 1'b1) : operandA;
  assign abs_b     = sgn_b ? (~operandB + 1'b1) : operandB;

  // Multiply: {partial, multiplier} shifts right; carry of the add enters the top bit.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: {remainder, dividend} shifts left; the shifted remainder needs one extra bit.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_sub  = rem_sh - {1'b0, mcand_q};
  assign div_next = (rem_sh >= {1'b0, mcand_q}) ?
                    {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1} :
                    {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    is_div_d  = is_div_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            3'd0, 3'd1: begin
              mcand_d   = abs_a;
              acc_d     = {{WIDTH{1'b0}}, abs_b};
              neg_d     = sgn_a ^ sgn_b;
              rem_neg_d = sgn_a;
              dz_d      = 1'b0;
              is_div_d  = 1'b0;
              cnt_d     = '0;
              busy_d    = 1'b1;
              state_d   = S_MUL;
            end
            3'd2, 3'd3: begin
              mcand_d   = abs_b;
              acc_d     = {{WIDTH{1'b0}}, abs_a};
              neg_d     = sgn_a ^ sgn_b;
              rem_neg_d = sgn_a;
              is_div_d  = 1'b1;
              cnt_d     = '0;
              busy_d    = 1'b1;
              dz_d      = (operandB == '0);
              state_d   = (operandB == '0) ? S_FIX : S_DIV;
            end
            3'd4:    hi_d = operandA;
            3'd5:    lo_d = operandA;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // Divide by zero leaves HI/LO untouched but still completes.
        if (!dz_q) begin
          if (is_div_q) begin
            lo_d = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            hi_d = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            hi_d = prod_fixed[2*WIDTH-1:WIDTH];
            lo_d = prod_fixed[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cancel && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
